// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A source operand collides with a destination only if it is actually read.
  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Combinational load-use comparator between the FD sources and the DX load target.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       load_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  output logic       hz_o
);

  // Writes to r0 are discarded, so they can never feed a stale value.
  assign hz_o = load_i && (rd_i != REG_ZERO) &&
                (src_match(use_rs1_i, rs1_i, rd_i) || src_match(use_rs2_i, rs2_i, rd_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch/decode sequencing: load-use bubbles, redirect flushes, mult/div handshake
// and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic [4:0]       rs1FD,
  input  logic [4:0]       rs2FD,
  input  logic             useRs1FD,
  input  logic             useRs2FD,
  input  logic             loadDX,
  input  logic [4:0]       rdDX,
  input  logic             mdOpFD,
  input  logic             mdReady,
  input  logic             brTakenXM,
  input  logic             jumpXM,
  output logic             stallA,
  output logic             stallPC,
  output logic             flushFD,
  output logic             flushDX,
  output logic             mdStart,
  output logic             mdAbort,
  output logic             mdBusy,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [1:0]       dbg_state_o
);

  localparam int WCNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               redir, hz, wait_last;

  hazard_cmp u_hazard_cmp (
    .load_i    (loadDX),
    .rd_i      (rdDX),
    .rs1_i     (rs1FD),
    .rs2_i     (rs2FD),
    .use_rs1_i (useRs1FD),
    .use_rs2_i (useRs2FD),
    .hz_o      (hz)
  );

  assign redir     = brTakenXM | jumpXM;
  assign wait_last = (wcnt_q == WCNT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      if (stallPC && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (!redir && !hz && mdOpFD) begin
          state_d = MD_WAIT;
          wcnt_d  = '0;
        end
      end
      MD_WAIT: begin
        // Redirect beats a simultaneous ready; ready beats the timeout.
        if (redir) begin
          state_d = RUN;
        end else if (mdReady) begin
          state_d = MD_DONE;
        end else if (wait_last) begin
          state_d   = MD_DONE;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      MD_DONE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Mealy control outputs; held low for the whole time reset is asserted.
  always_comb begin
    stallA  = 1'b0;
    stallPC = 1'b0;
    flushFD = 1'b0;
    flushDX = 1'b0;
    mdStart = 1'b0;
    mdAbort = 1'b0;
    mdBusy  = 1'b0;
    if (aclr_n) begin
      case (state_q)
        RUN: begin
          if (redir) begin
            flushFD = 1'b1;
            flushDX = 1'b1;
          end else if (hz) begin
            stallA  = 1'b1;
            stallPC = 1'b1;
          end else if (mdOpFD) begin
            mdStart = 1'b1;
            stallA  = 1'b1;
            stallPC = 1'b1;
          end
        end
        MD_WAIT: begin
          mdBusy = 1'b1;
          if (redir) begin
            flushFD = 1'b1;
            flushDX = 1'b1;
            mdAbort = 1'b1;
          end else begin
            stallA  = 1'b1;
            stallPC = 1'b1;
          end
        end
        MD_DONE: begin
          if (redir) begin
            flushFD = 1'b1;
            flushDX = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdTimeout   = timeout_q;
  assign stallCycles = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  // clock / reset
  logic clock = 1'b0;
  logic aclr_n;
  always #5 clock = ~clock;

  logic [4:0]    rs1FD, rs2FD, rdDX;
  logic          useRs1FD, useRs2FD, loadDX, mdOpFD, mdReady, brTakenXM, jumpXM;
  logic          stallA, stallPC, flushFD, flushDX, mdStart, mdAbort, mdBusy, mdTimeout;
  logic [CW-1:0] stallCycles;
  logic [1:0]    dbg_state_o;

  pipe_ctrl #(.MD_TIMEOUT(T), .CNT_W(CW)) dut (
    .clock(clock), .aclr_n(aclr_n),
    .rs1FD(rs1FD), .rs2FD(rs2FD), .useRs1FD(useRs1FD), .useRs2FD(useRs2FD),
    .loadDX(loadDX), .rdDX(rdDX), .mdOpFD(mdOpFD), .mdReady(mdReady),
    .brTakenXM(brTakenXM), .jumpXM(jumpXM),
    .stallA(stallA), .stallPC(stallPC), .flushFD(flushFD), .flushDX(flushDX),
    .mdStart(mdStart), .mdAbort(mdAbort), .mdBusy(mdBusy), .mdTimeout(mdTimeout),
    .stallCycles(stallCycles), .dbg_state_o(dbg_state_o)
  );

  // scoreboard
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // behavioural model: mode 0 running, 1 waiting on mult/div, 2 one-cycle release
  int m_mode, m_waits, m_stalls, starts_seen;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1FD = 5'd0; rs2FD = 5'd0; rdDX = 5'd0;
    useRs1FD = 1'b0; useRs2FD = 1'b0; loadDX = 1'b0;
    mdOpFD = 1'b0; mdReady = 1'b0; brTakenXM = 1'b0; jumpXM = 1'b0;
  endtask

  // Asserts reset with whatever inputs the caller left applied.
  task automatic apply_reset();
    aclr_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({stallA, stallPC, flushFD, flushDX, mdStart, mdAbort, mdBusy}), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    check("rst_timeout", 32'(mdTimeout), 32'd0);
    check("rst_stallcnt", 32'(stallCycles), 32'd0);
    m_mode = 0; m_waits = 0; m_to = 0; m_stalls = 0;
    @(posedge clock);
    #1;
    check("rst_hold_ctrl", 32'({stallA, stallPC, flushFD, flushDX, mdStart, mdAbort, mdBusy}), 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;
  endtask

  // One clock of stimulus: inputs are already applied at the negedge.
  task automatic run_cycle();
    bit redir, hz, sa, sp, ff, fd, ms, ma, mb, n_to;
    int nmode, n_waits;
    logic [6:0] e, got;
    #1;
    redir = brTakenXM || jumpXM;
    hz = loadDX && (rdDX != 5'd0) &&
         ((useRs1FD && rs1FD == rdDX) || (useRs2FD && rs2FD == rdDX));
    {sa, sp, ff, fd, ms, ma, mb} = 7'd0;
    nmode = m_mode; n_waits = m_waits; n_to = m_to;
    if (m_mode == 0) begin
      if (redir) begin ff = 1; fd = 1; end
      else if (hz) begin sa = 1; sp = 1; end
      else if (mdOpFD) begin ms = 1; sa = 1; sp = 1; nmode = 1; n_waits = 0; end
    end else if (m_mode == 1) begin
      mb = 1;
      if (redir) begin ff = 1; fd = 1; ma = 1; nmode = 0; end
      else begin
        sa = 1; sp = 1;
        n_waits = m_waits + 1;
        if (mdReady) nmode = 2;
        else if (n_waits == T) begin nmode = 2; n_to = 1; end
      end
    end else begin
      if (redir) begin ff = 1; fd = 1; end
      nmode = 0;
    end
    exp_q.push_back({sa, sp, ff, fd, ms, ma, mb});
    got = {stallA, stallPC, flushFD, flushDX, mdStart, mdAbort, mdBusy};
    e = exp_q.pop_front();
    check("ctrl", 32'(got), 32'(e));
    check("state", 32'(dbg_state_o), 32'(m_mode));
    check("timeout", 32'(mdTimeout), 32'(m_to));
    check("stallcnt", 32'(stallCycles), 32'(m_stalls));
    if (mdStart) starts_seen++;
    @(posedge clock);
    m_mode = nmode; m_waits = n_waits; m_to = n_to;
    if (sp && m_stalls < SMAX) m_stalls++;
    @(negedge clock);
  endtask

  initial begin
    // reset with redirect and mult/div requests applied
    clear_inputs();
    brTakenXM = 1'b1; mdOpFD = 1'b1;
    apply_reset();
    clear_inputs();

    // load-use on rs2, then the bubble clears the load
    loadDX = 1'b1; rdDX = 5'd5; rs2FD = 5'd5; useRs2FD = 1'b1;
    run_cycle();
    loadDX = 1'b0;
    run_cycle();
    check("lu_cost", 32'(stallCycles), 32'd1);
    // load into r0 never stalls
    loadDX = 1'b1; rdDX = 5'd0; rs1FD = 5'd0; rs2FD = 5'd0; useRs1FD = 1'b1;
    run_cycle();
    check("lu_r0", 32'(stallCycles), 32'd1);

    // mult/div: ready arrives on the fourth wait cycle, together with the timeout point
    clear_inputs();
    apply_reset();
    starts_seen = 0;
    mdOpFD = 1'b1;
    run_cycle();
    for (int i = 0; i < 4; i++) begin
      mdReady = (i == 3);
      run_cycle();
    end
    mdReady = 1'b0;
    run_cycle();
    mdOpFD = 1'b0;
    check("md_stallcnt", 32'(stallCycles), 32'd5);
    check("md_starts", 32'(starts_seen), 32'd1);
    check("md_no_timeout", 32'(mdTimeout), 32'd0);
    run_cycle();

    // timeout: ready never comes
    apply_reset();
    mdOpFD = 1'b1;
    run_cycle();
    for (int i = 0; i < T; i++) run_cycle();
    check("to_flag", 32'(mdTimeout), 32'd1);
    check("to_done", 32'(dbg_state_o), 32'd2);
    run_cycle();
    check("to_run", 32'(dbg_state_o), 32'd0);
    mdOpFD = 1'b0;
    run_cycle();

    // abort: jump and ready together in a wait cycle
    apply_reset();
    mdOpFD = 1'b1;
    run_cycle();
    run_cycle();
    jumpXM = 1'b1; mdReady = 1'b1;
    run_cycle();
    jumpXM = 1'b0; mdReady = 1'b0; mdOpFD = 1'b0;
    check("abort_run", 32'(dbg_state_o), 32'd0);
    run_cycle();

    // reset during a wait does not abort
    mdOpFD = 1'b1;
    run_cycle();
    run_cycle();
    apply_reset();
    clear_inputs();

    // saturation of the stall counter
    loadDX = 1'b1; rdDX = 5'd7; rs1FD = 5'd7; useRs1FD = 1'b1;
    for (int i = 0; i < 20; i++) run_cycle();
    check("sat", 32'(stallCycles), 32'(SMAX));
    clear_inputs();

    // randomized traffic
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      rs1FD     = 5'($urandom_range(0, 3));
      rs2FD     = 5'($urandom_range(0, 3));
      rdDX      = 5'($urandom_range(0, 3));
      useRs1FD  = 1'($urandom_range(0, 1));
      useRs2FD  = 1'($urandom_range(0, 1));
      loadDX    = ($urandom_range(0, 2) == 0);
      mdOpFD    = ($urandom_range(0, 3) == 0);
      mdReady   = ($urandom_range(0, 2) == 0);
      brTakenXM = ($urandom_range(0, 11) == 0);
      jumpXM    = ($urandom_range(0, 15) == 0);
      run_cycle();
      if (i == 250) begin
        apply_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
